sha256_job_scheduler: RTL and testbench
=======================================

// Module: sha256_job_scheduler
// PURPOSE
// - Shares one sha256_engine between NUM_CH requesters at message granularity.
// - Grants a channel round-robin and forwards its cfg beat, then its data blocks up to data_in_last.
// - Records each granted channel ID in an in-order ID queue.
// - Routes each returned hash to the channel at the queue head. Sits between host channels and the engine.
// PARAMETERS
// - NUM_CH      2  number of requester channels (>=2)
// - ID_DEPTH    4  ID queue depth = max messages in flight inside the engine
// PORTS
// clk                  in   1            clock; single clock domain
// sync_rst             in   1            reset; synchronous, active-high
// en                   in   1            0: stall (all valid/ready outputs 0, state held)
// ch_cfg_size          in   NUM_CHx64    per-channel message size in bits
// ch_cfg_scheme        in   NUM_CHx2     per-channel scheme
// ch_cfg_last          in   NUM_CH       per-channel cfg last
// ch_cfg_valid         in   NUM_CH       per-channel cfg valid (request)
// ch_cfg_ready         out  NUM_CH       per-channel cfg ready
// ch_data_in           in   NUM_CHx512   per-channel message block
// ch_data_in_last      in   NUM_CH       last block of message
// ch_data_in_valid     in   NUM_CH       block valid
// ch_data_in_ready     out  NUM_CH       block ready
// ch_data_out          out  256          hash, broadcast to all channels
// ch_data_out_last     out  1            hash last, broadcast
// ch_data_out_valid    out  NUM_CH       one-hot hash valid
// ch_data_out_ready    in   NUM_CH       hash ready
// eng_cfg_size/scheme/last/valid  out  64/2/1/1  to engine cfg port
// eng_cfg_ready        in   1
// eng_data_in/last/valid          out  512/1/1   to engine data port
// eng_data_in_ready    in   1
// eng_data_out/last/valid         in   256/1/1   from engine
// eng_data_out_ready   out  1
// busy                 out  1            FSM not IDLE or ID queue non-empty
// err_orphan_hash      out  1            sticky: engine hash with empty ID queue
// BEHAVIOUR
// - Reset (sync_rst=1 at clk edge) has priority over en.
//   - State IDLE, last_grant=NUM_CH-1, ID queue flushed, err_orphan_hash=0.
//   - All valid/ready outputs 0.
//   - Mid-message reset abandons the message; the engine shares sync_rst.
// - FSM IDLE:
//   - If any ch_cfg_valid and ID queue not full: register grant cur_ch.
//   - cur_ch = first requester from (last_grant+1) mod NUM_CH upward.
//   - Go to CFG. Grant costs 1 cycle; cfg reaches the engine the cycle after the request is seen.
// - FSM CFG:
//   - eng_cfg_* = ch_cfg_*[cur_ch]; ch_cfg_ready[cur_ch] = eng_cfg_ready; others 0.
//   - On handshake: push cur_ch into ID queue; go to DATA.
//   - A requester must not drop cfg_valid once granted; the FSM waits.
// - FSM DATA:
//   - eng_data_in_* = ch_data_in_*[cur_ch]; ch_data_in_ready[cur_ch] = eng_data_in_ready.
//   - On handshake with last=1: last_grant<=cur_ch; go to IDLE. No data or cfg passes in any other state.
// - Return path (combinational):
//   - Queue non-empty: ch_data_out_valid[head] = eng_data_out_valid; eng_data_out_ready = ch_data_out_ready[head].
//   - Pop on a handshake with eng_data_out_last=1. Non-last hash beats go to the same head.
//   - Queue empty: eng_data_out_ready=0; if eng_data_out_valid, set err_orphan_hash.
// - Queue full: IDLE grants nothing. Push and pop in the same cycle leave the count unchanged.
//   - Push is legal when full only with a simultaneous pop.
// - en=0: no FSM transition, no push/pop; handshake outputs forced 0.
// STRUCTURE
// - sha256_pkg:
//   - constants DATA_W=512, HASH_W=256, SIZE_W=64, SCHEME_W=2.
//   - enum sched_state_t {IDLE,CFG,DATA}.
// - Sub-module rr_arbiter: NUM_CH-wide round-robin, request+last_grant -> one-hot/index.
// - ID queue is an existing fifo_vr instance (DATA_W=$clog2(NUM_CH), DEPTH=ID_DEPTH).
// TESTING
// - Directed scenarios:
//   1. ch0 sends cfg size=1000, scheme=0, 2 blocks (last on 2nd); engine returns 1 hash, last=1.
//      -> only ch_data_out_valid[0] rises; FSM IDLE; busy=0 after pop.
//   2. ch0 and ch1 request in the same cycle after reset.
//      -> ch0 served first, ch1 next; hashes H0,H1 delivered to ch0 then ch1.
//   3. ch0 ch_data_out_ready=0 for 10 cycles while ch1's hash queues behind.
//      -> eng_data_out_ready=0, H0 held stable, ch1 never sees valid before H0 pops.
//   4. ID_DEPTH=4, engine output stalled, 5 single-block messages submitted.
//      -> first 4 granted, 5th cfg_ready=0 until one hash is popped, then granted.
//   5. sync_rst pulsed in DATA after block 1 of 3.
//      -> next cycle all valid/ready=0, IDLE, queue empty, next grant goes to ch0.
//   6. eng_data_out_valid=1 with queue empty.
//      -> eng_data_out_ready=0, err_orphan_hash=1 and stays 1 until sync_rst.

Source files
------------

// File: rtl/sha256_pkg.sv
// sha256_pkg: shared widths and scheduler state encoding for the sha256 job scheduler
package sha256_pkg;
  localparam int DATA_W   = 512;
  localparam int HASH_W   = 256;
  localparam int SIZE_W   = 64;
  localparam int SCHEME_W = 2;
  typedef enum logic [1:0] {IDLE, CFG, DATA} sched_state_t;
endpackage

// File: rtl/fifo_vr.sv
// fifo_vr: valid/ready FIFO; a push into a full FIFO is accepted only alongside a pop
module fifo_vr #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr, r_rd;
  logic [CW-1:0]     r_cnt;
  logic              w_push, w_pop;
  assign o_ready = r_cnt != CW'(DEPTH);
  assign o_valid = r_cnt != '0;
  assign o_data  = r_mem[r_rd];
  assign w_pop   = o_valid & i_ready;
  assign w_push  = i_valid & (o_ready | w_pop);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_mem[r_wr] <= i_data;
      if (w_push) r_wr <= r_wr == AW'(DEPTH - 1) ? '0 : r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd == AW'(DEPTH - 1) ? '0 : r_rd + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/sha256_job_scheduler_rr_arbiter.sv
// rr_arbiter: picks the first requester after i_last, wrapping, as one-hot and index
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);
  logic [IW-1:0] w_c;
  always_comb begin
    w_c   = '0;
    o_idx = '0;
    o_any = 1'b0;
    // descending scan so the nearest candidate after i_last wins
    for (int k = N; k >= 1; k--) begin
      w_c = IW'((int'(i_last) + k) % N);
      if (i_req[w_c]) begin
        o_idx = w_c;
        o_any = 1'b1;
      end
    end
    o_gnt = o_any ? N'(1) << o_idx : '0;
  end
endmodule

// File: rtl/sha256_job_scheduler.sv
// sha256_job_scheduler: shares one sha256 engine between channels per message and
// routes each returned hash back to its requester through an in-order ID queue
module sha256_job_scheduler
  import sha256_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int ID_DEPTH = 4,
  localparam int CH_W = $clog2(NUM_CH)
) (
  input  logic                             clk,
  input  logic                             sync_rst,
  input  logic                             en,
  input  logic [NUM_CH-1:0][SIZE_W-1:0]    ch_cfg_size,
  input  logic [NUM_CH-1:0][SCHEME_W-1:0]  ch_cfg_scheme,
  input  logic [NUM_CH-1:0]                ch_cfg_last,
  input  logic [NUM_CH-1:0]                ch_cfg_valid,
  output logic [NUM_CH-1:0]                ch_cfg_ready,
  input  logic [NUM_CH-1:0][DATA_W-1:0]    ch_data_in,
  input  logic [NUM_CH-1:0]                ch_data_in_last,
  input  logic [NUM_CH-1:0]                ch_data_in_valid,
  output logic [NUM_CH-1:0]                ch_data_in_ready,
  output logic [HASH_W-1:0]                ch_data_out,
  output logic                             ch_data_out_last,
  output logic [NUM_CH-1:0]                ch_data_out_valid,
  input  logic [NUM_CH-1:0]                ch_data_out_ready,
  output logic [SIZE_W-1:0]                eng_cfg_size,
  output logic [SCHEME_W-1:0]              eng_cfg_scheme,
  output logic                             eng_cfg_last,
  output logic                             eng_cfg_valid,
  input  logic                             eng_cfg_ready,
  output logic [DATA_W-1:0]                eng_data_in,
  output logic                             eng_data_in_last,
  output logic                             eng_data_in_valid,
  input  logic                             eng_data_in_ready,
  input  logic [HASH_W-1:0]                eng_data_out,
  input  logic                             eng_data_out_last,
  input  logic                             eng_data_out_valid,
  output logic                             eng_data_out_ready,
  output logic                             busy,
  output logic                             err_orphan_hash
);
  sched_state_t      r_state;
  logic [CH_W-1:0]   r_cur_ch, r_last_grant;
  logic [NUM_CH-1:0] r_cur_oh;
  logic              r_err;
  logic [NUM_CH-1:0] w_gnt_oh;
  logic [CH_W-1:0]   w_gnt_idx, w_head;
  logic              w_any, w_q_ready, w_q_valid, w_in_cfg, w_in_data, w_push, w_pop, w_din_done;
  rr_arbiter #(.N(NUM_CH)) u_arb (
    .i_req (ch_cfg_valid),
    .i_last(r_last_grant),
    .o_gnt (w_gnt_oh),
    .o_idx (w_gnt_idx),
    .o_any (w_any)
  );
  fifo_vr #(.DATA_W(CH_W), .DEPTH(ID_DEPTH)) u_id_q (
    .clk    (clk),
    .rst    (sync_rst),
    .i_data (r_cur_ch),
    .i_valid(w_push),
    .o_ready(w_q_ready),
    .o_data (w_head),
    .o_valid(w_q_valid),
    .i_ready(w_pop)
  );
  assign w_in_cfg  = en & (r_state == CFG);
  assign w_in_data = en & (r_state == DATA);
  assign eng_cfg_size      = ch_cfg_size[r_cur_ch];
  assign eng_cfg_scheme    = ch_cfg_scheme[r_cur_ch];
  assign eng_cfg_last      = ch_cfg_last[r_cur_ch];
  assign eng_cfg_valid     = w_in_cfg & ch_cfg_valid[r_cur_ch];
  assign ch_cfg_ready      = w_in_cfg & eng_cfg_ready ? r_cur_oh : '0;
  assign eng_data_in       = ch_data_in[r_cur_ch];
  assign eng_data_in_last  = ch_data_in_last[r_cur_ch];
  assign eng_data_in_valid = w_in_data & ch_data_in_valid[r_cur_ch];
  assign ch_data_in_ready  = w_in_data & eng_data_in_ready ? r_cur_oh : '0;
  assign w_push     = eng_cfg_valid & eng_cfg_ready;
  assign w_din_done = eng_data_in_valid & eng_data_in_ready & eng_data_in_last;
  // hashes return in grant order, so the queue head names the owner
  assign ch_data_out        = eng_data_out;
  assign ch_data_out_last   = eng_data_out_last;
  assign ch_data_out_valid  = en & w_q_valid & eng_data_out_valid ? NUM_CH'(1) << w_head : '0;
  assign eng_data_out_ready = en & w_q_valid & ch_data_out_ready[w_head];
  assign w_pop              = eng_data_out_valid & eng_data_out_ready & eng_data_out_last;
  assign busy            = (r_state != IDLE) | w_q_valid;
  assign err_orphan_hash = r_err;
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      r_state      <= IDLE;
      r_last_grant <= CH_W'(NUM_CH - 1);
      r_cur_ch     <= '0;
      r_cur_oh     <= '0;
      r_err        <= 1'b0;
    end else begin
      r_err <= r_err | (en & ~w_q_valid & eng_data_out_valid);
      if (en && r_state == IDLE && w_any && w_q_ready) begin
        r_cur_ch <= w_gnt_idx;
        r_cur_oh <= w_gnt_oh;
        r_state  <= CFG;
      end
      if (w_push) r_state <= DATA;
      if (w_din_done) begin
        r_last_grant <= r_cur_ch;
        r_state      <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_sha256_job_scheduler.sv
// tb_sha256_job_scheduler: host channels and engine modelled as message-level queues;
// every hash a channel receives must equal the digest of the message it submitted
module tb_sha256_job_scheduler;
  import sha256_pkg::*;
  localparam int NC = 2;
  localparam int IDD = 4;
  logic clk = 1'b0;
  logic sync_rst, en;
  logic [NC-1:0][SIZE_W-1:0]   ch_cfg_size;
  logic [NC-1:0][SCHEME_W-1:0] ch_cfg_scheme;
  logic [NC-1:0]               ch_cfg_last, ch_cfg_valid, ch_cfg_ready;
  logic [NC-1:0][DATA_W-1:0]   ch_data_in;
  logic [NC-1:0]               ch_data_in_last, ch_data_in_valid, ch_data_in_ready;
  logic [HASH_W-1:0]           ch_data_out;
  logic                        ch_data_out_last;
  logic [NC-1:0]               ch_data_out_valid, ch_data_out_ready;
  logic [SIZE_W-1:0]           eng_cfg_size;
  logic [SCHEME_W-1:0]         eng_cfg_scheme;
  logic                        eng_cfg_last, eng_cfg_valid, eng_cfg_ready;
  logic [DATA_W-1:0]           eng_data_in;
  logic                        eng_data_in_last, eng_data_in_valid, eng_data_in_ready;
  logic [HASH_W-1:0]           eng_data_out;
  logic                        eng_data_out_last, eng_data_out_valid, eng_data_out_ready;
  logic                        busy, err_orphan_hash;

  sha256_job_scheduler #(.NUM_CH(NC), .ID_DEPTH(IDD)) dut (
    .clk(clk), .sync_rst(sync_rst), .en(en),
    .ch_cfg_size(ch_cfg_size), .ch_cfg_scheme(ch_cfg_scheme), .ch_cfg_last(ch_cfg_last),
    .ch_cfg_valid(ch_cfg_valid), .ch_cfg_ready(ch_cfg_ready),
    .ch_data_in(ch_data_in), .ch_data_in_last(ch_data_in_last),
    .ch_data_in_valid(ch_data_in_valid), .ch_data_in_ready(ch_data_in_ready),
    .ch_data_out(ch_data_out), .ch_data_out_last(ch_data_out_last),
    .ch_data_out_valid(ch_data_out_valid), .ch_data_out_ready(ch_data_out_ready),
    .eng_cfg_size(eng_cfg_size), .eng_cfg_scheme(eng_cfg_scheme), .eng_cfg_last(eng_cfg_last),
    .eng_cfg_valid(eng_cfg_valid), .eng_cfg_ready(eng_cfg_ready),
    .eng_data_in(eng_data_in), .eng_data_in_last(eng_data_in_last),
    .eng_data_in_valid(eng_data_in_valid), .eng_data_in_ready(eng_data_in_ready),
    .eng_data_out(eng_data_out), .eng_data_out_last(eng_data_out_last),
    .eng_data_out_valid(eng_data_out_valid), .eng_data_out_ready(eng_data_out_ready),
    .busy(busy), .err_orphan_hash(err_orphan_hash)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0]      size;
    logic [1:0]       scheme;
    logic [2:0]       nblk;
    logic [3:0][511:0] blk;
  } msg_t;

  msg_t         msg_q [NC][$];
  msg_t         cur [NC];
  int           ph [NC];
  int           bi [NC];
  logic [255:0] exp_q [NC][$];
  int           eng_ph;
  logic [255:0] eng_acc;
  logic [255:0] eng_out_q [$];
  int           grant_log [$];
  int           deliv_log [$];
  int           p_cfg, p_din, p_dv, en_pct;
  int           p_ordy [NC];
  bit           out_hold;
  int           checks = 0;
  int           errors = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] hinit(input logic [63:0] size, input logic [1:0] scheme);
    return {190'd0, scheme, size};
  endfunction

  function automatic logic [255:0] hstep(input logic [255:0] h, input logic [511:0] b);
    return {h[254:0], h[255]} ^ b[255:0] ^ b[511:256];
  endfunction

  function automatic logic [255:0] msg_hash(input msg_t m);
    logic [255:0] h = hinit(m.size, m.scheme);
    for (int i = 0; i < int'(m.nblk); i++) h = hstep(h, m.blk[i]);
    return h;
  endfunction

  task automatic add_msg(input int c, input int nblk, input logic [63:0] size, input logic [1:0] scheme);
    msg_t m;
    m.size = size;
    m.scheme = scheme;
    m.nblk = 3'(nblk);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 16; j++) m.blk[i][j*32 +: 32] = $urandom;
    msg_q[c].push_back(m);
    exp_q[c].push_back(msg_hash(m));
  endtask

  task automatic drive_idle();
    en = 1'b1;
    ch_cfg_size = '0; ch_cfg_scheme = '0; ch_cfg_last = '0; ch_cfg_valid = '0;
    ch_data_in = '0; ch_data_in_last = '0; ch_data_in_valid = '0; ch_data_out_ready = '0;
    eng_cfg_ready = 1'b0; eng_data_in_ready = 1'b0;
    eng_data_out = '0; eng_data_out_last = 1'b0; eng_data_out_valid = 1'b0;
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      msg_q[c].delete();
      exp_q[c].delete();
      ph[c] = 0;
      bi[c] = 0;
    end
    eng_ph = 0;
    eng_out_q.delete();
    grant_log.delete();
    deliv_log.delete();
    drive_idle();
  endtask

  task automatic do_reset();
    sync_rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 sync_rst = 1'b0;
  endtask

  function automatic bit idle();
    bit r = eng_out_q.size() == 0 && eng_ph == 0;
    for (int c = 0; c < NC; c++)
      r &= msg_q[c].size() == 0 && exp_q[c].size() == 0 && ph[c] == 0;
    return r;
  endfunction

  // one clock: observe handshakes mid-cycle, advance models after the edge, redrive
  task automatic cycle();
    logic [NC-1:0] chs, dhs;
    bit ecfg, edin, eout, dlast;
    logic [63:0] s_size;
    logic [1:0] s_scheme;
    logic [511:0] s_din;
    @(negedge clk);
    chs = ch_cfg_valid & ch_cfg_ready;
    dhs = ch_data_in_valid & ch_data_in_ready;
    ecfg = eng_cfg_valid & eng_cfg_ready;
    edin = eng_data_in_valid & eng_data_in_ready;
    eout = eng_data_out_valid & eng_data_out_ready;
    s_size = eng_cfg_size; s_scheme = eng_cfg_scheme; s_din = eng_data_in; dlast = eng_data_in_last;
    chk("out_onehot", 256'($onehot0(ch_data_out_valid)), 1);
    if (!en)
      chk("en_low_quiet", {ch_cfg_ready, ch_data_in_ready, ch_data_out_valid,
                           eng_cfg_valid, eng_data_in_valid, eng_data_out_ready}, 0);
    if (eng_cfg_valid) chk("cfg_while_engine_busy", eng_ph, 0);
    if (eng_data_in_valid) chk("data_without_cfg", eng_ph, 1);
    if (ecfg) chk("cfg_hs_single_src", $countones(chs), 1);
    if (eout) chk("hash_hs_reaches_ch", 256'(|(ch_data_out_valid & ch_data_out_ready)), 1);
    for (int c = 0; c < NC; c++) begin
      if (chs[c]) begin
        grant_log.push_back(c);
        chk("cfg_size_fwd", s_size, cur[c].size);
      end
      if (ch_data_out_valid[c] && exp_q[c].size() == 0) chk("hash_misroute", 1, 0);
      else if (ch_data_out_valid[c] && ch_data_out_ready[c]) begin
        chk("hash_value", ch_data_out, exp_q[c].pop_front());
        deliv_log.push_back(c);
      end
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < NC; c++) begin
      if (chs[c]) begin ph[c] = 2; bi[c] = 0; ch_cfg_valid[c] = 1'b0; end
      if (dhs[c]) begin
        ch_data_in_valid[c] = 1'b0;
        if (bi[c] == int'(cur[c].nblk) - 1) ph[c] = 0;
        else bi[c]++;
      end
    end
    if (ecfg) begin eng_ph = 1; eng_acc = hinit(s_size, s_scheme); end
    if (edin) begin
      eng_acc = hstep(eng_acc, s_din);
      if (dlast) begin eng_out_q.push_back(eng_acc); eng_ph = 0; end
    end
    if (eout) void'(eng_out_q.pop_front());
    for (int c = 0; c < NC; c++) begin
      if (ph[c] == 0 && msg_q[c].size() > 0) begin
        cur[c] = msg_q[c].pop_front();
        ph[c] = 1;
        ch_cfg_valid[c] = 1'b1;
        ch_cfg_size[c] = cur[c].size;
        ch_cfg_scheme[c] = cur[c].scheme;
        ch_cfg_last[c] = 1'b1;
      end
      if (ph[c] == 2 && !ch_data_in_valid[c] && $urandom_range(99) < p_dv) begin
        ch_data_in[c] = cur[c].blk[bi[c]];
        ch_data_in_last[c] = bi[c] == int'(cur[c].nblk) - 1;
        ch_data_in_valid[c] = 1'b1;
      end
      ch_data_out_ready[c] = $urandom_range(99) < p_ordy[c];
    end
    eng_cfg_ready = eng_ph == 0 && $urandom_range(99) < p_cfg;
    eng_data_in_ready = eng_ph == 1 && $urandom_range(99) < p_din;
    eng_data_out_valid = eng_out_q.size() > 0 && !out_hold;
    eng_data_out = eng_out_q.size() > 0 ? eng_out_q[0] : '0;
    eng_data_out_last = 1'b1;
    en = $urandom_range(99) < en_pct;
  endtask

  task automatic run_until_idle(input string tag, input int max);
    int n = 0;
    do begin cycle(); n++; end while (!idle() && n < max);
    chk({tag, "_completes"}, 256'(idle()), 1);
  endtask

  task automatic knobs_full();
    p_cfg = 100; p_din = 100; p_dv = 100; en_pct = 100; out_hold = 0;
    for (int c = 0; c < NC; c++) p_ordy[c] = 100;
  endtask

  initial begin
    knobs_full();
    do_reset();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_orphan_hash, 0);
    chk("rst_handshakes", {ch_cfg_ready, ch_data_in_ready, ch_data_out_valid,
                           eng_cfg_valid, eng_data_in_valid, eng_data_out_ready}, 0);

    // single two-block message from ch0
    add_msg(0, 2, 64'd1000, 2'd0);
    run_until_idle("s1", 100);
    chk("s1_deliv_cnt", deliv_log.size(), 1);
    chk("s1_deliv_ch", deliv_log[0], 0);
    chk("s1_busy", busy, 0);

    // simultaneous requests after reset: ch0 first
    do_reset();
    add_msg(0, 1, 64'd512, 2'd1);
    add_msg(1, 1, 64'd256, 2'd2);
    run_until_idle("s2", 100);
    chk("s2_grant0", grant_log[0], 0);
    chk("s2_grant1", grant_log[1], 1);
    chk("s2_deliv0", deliv_log[0], 0);
    chk("s2_deliv1", deliv_log[1], 1);

    // ch0 stalls its hash; ch1's hash must wait behind it
    do_reset();
    p_ordy[0] = 0;
    add_msg(0, 1, 64'd100, 2'd0);
    add_msg(1, 2, 64'd900, 2'd3);
    repeat (30) cycle();
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("s3_eng_rdy_low", eng_data_out_ready, 0);
      chk("s3_valid_ch0_only", ch_data_out_valid, 2'b01);
      chk("s3_h0_stable", ch_data_out, exp_q[0][0]);
    end
    chk("s3_none_delivered", deliv_log.size(), 0);
    p_ordy[0] = 100;
    run_until_idle("s3", 100);
    chk("s3_order0", deliv_log[0], 0);
    chk("s3_order1", deliv_log[1], 1);

    // ID queue full: the fifth message waits for a pop
    knobs_full();
    do_reset();
    out_hold = 1;
    for (int i = 0; i < 5; i++) add_msg(i % NC, 1, 64'(i + 1), 2'(i));
    repeat (40) cycle();
    chk("s4_grants_capped", grant_log.size(), IDD);
    chk("s4_cfg_ready_low", ch_cfg_ready, 0);
    chk("s4_busy", busy, 1);
    out_hold = 0;
    run_until_idle("s4", 200);
    chk("s4_grants_all", grant_log.size(), 5);
    chk("s4_deliv_all", deliv_log.size(), 5);

    // reset in the middle of a three-block message
    do_reset();
    add_msg(0, 1, 64'd7, 2'd0);
    run_until_idle("s5_pre", 100);
    add_msg(1, 3, 64'd1536, 2'd1);
    begin
      int n = 0;
      while (!(ph[1] == 2 && bi[1] >= 1) && n < 100) begin cycle(); n++; end
      chk("s5_reached_block1", 256'(ph[1] == 2 && bi[1] >= 1), 1);
    end
    sync_rst = 1'b1;
    @(posedge clk);
    #1 sync_rst = 1'b0;
    ch_data_in_valid[1] = 1'b1;
    ch_cfg_valid = '0;
    eng_cfg_ready = 1'b1;
    eng_data_in_ready = 1'b1;
    @(negedge clk);
    chk("s5_quiet", {ch_cfg_ready, ch_data_in_ready, ch_data_out_valid,
                     eng_cfg_valid, eng_data_in_valid, eng_data_out_ready}, 0);
    chk("s5_busy", busy, 0);
    @(posedge clk);
    #1 model_reset();
    add_msg(0, 1, 64'd11, 2'd0);
    add_msg(1, 1, 64'd22, 2'd0);
    run_until_idle("s5", 100);
    chk("s5_first_grant", grant_log[0], 0);

    // engine hash with nothing in flight
    do_reset();
    eng_data_out_valid = 1'b1;
    eng_data_out_last = 1'b1;
    @(negedge clk);
    chk("s6_eng_rdy", eng_data_out_ready, 0);
    chk("s6_no_route", ch_data_out_valid, 0);
    chk("s6_err_not_yet", err_orphan_hash, 0);
    @(posedge clk);
    #1 eng_data_out_valid = 1'b0;
    @(negedge clk);
    chk("s6_err_set", err_orphan_hash, 1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("s6_err_sticky", err_orphan_hash, 1);
    do_reset();
    @(negedge clk);
    chk("s6_err_cleared", err_orphan_hash, 0);

    // randomized traffic with backpressure on every port and en toggling
    do_reset();
    p_cfg = 60; p_din = 70; p_dv = 70; en_pct = 85;
    for (int c = 0; c < NC; c++) p_ordy[c] = 55;
    for (int i = 0; i < 60; i++)
      add_msg($urandom_range(NC - 1), $urandom_range(1, 4), {$urandom, $urandom}, 2'($urandom_range(3)));
    run_until_idle("rand", 20000);
    chk("rand_deliv_all", deliv_log.size(), 60);
    chk("rand_no_orphan", err_orphan_hash, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
